// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat, 64-bit burst protocol.
// It accepts a line-aligned read or write, waits LATENCY idle cycles, and then moves
// four 64-bit beats in consecutive cycles with resp_o high on each beat.
// Backing store is an array of 256-bit lines that reset does not clear.
module burst_mem_responder #(
  parameter int unsigned DEPTH_LINES = 16,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  // lat_cnt only ever holds LATENCY-1 down to 0.
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst,
    StDone
  } state_e;

  state_e             r_state, w_state_next;
  logic               r_op_write, w_op_write_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic [LAT_W-1:0]   r_lat_cnt, w_lat_cnt_next;
  logic [1:0]         r_beat, w_beat_next;

  logic [255:0]       r_mem [DEPTH_LINES];

  logic               w_accept;
  logic               w_beat_write;
  logic [7:0]         w_beat_lsb;
  logic               w_unused_addr;

  // Address bits outside the line index are don't-care (offset bits and aliasing bits).
  assign w_unused_addr = ^{address_i[31:5+IDX_W], address_i[4:0]};

  assign w_accept     = read_i | write_i;
  assign w_beat_lsb   = {r_beat, 6'b000000};
  // A reset edge takes priority, so the beat under reset is never committed.
  assign w_beat_write = reset_n && (r_state == StBurst) && r_op_write;

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_lat_cnt  <= '0;
      r_beat     <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_op_write <= w_op_write_next;
      r_idx      <= w_idx_next;
      r_lat_cnt  <= w_lat_cnt_next;
      r_beat     <= w_beat_next;
    end
  end

  // Next-state logic: accept, wait out the latency, step through four beats, then one dead cycle.
  always_comb begin
    w_state_next    = r_state;
    w_op_write_next = r_op_write;
    w_idx_next      = r_idx;
    w_lat_cnt_next  = r_lat_cnt;
    w_beat_next     = r_beat;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          // Read wins when both requests are high.
          w_op_write_next = ~read_i;
          w_idx_next      = address_i[5 +: IDX_W];
          w_beat_next     = 2'd0;
          if (LATENCY > 0) begin
            w_state_next   = StWait;
            w_lat_cnt_next = LAT_W'(LATENCY - 1);
          end else begin
            w_state_next   = StBurst;
          end
        end
      end
      StWait: begin
        if (r_lat_cnt == '0) begin
          w_state_next = StBurst;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 1'b1;
        end
      end
      StBurst: begin
        w_beat_next = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        // Requests are ignored here so the initiator has a cycle to drop them.
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Line storage: commit one 64-bit beat per burst cycle of a write; never reset.
  always_ff @(posedge clk) begin
    if (w_beat_write) begin
      r_mem[r_idx][w_beat_lsb +: 64] <= burst_i;
    end
  end

  // Outputs: beat strobe during the burst, and read data that is zero outside read beats.
  always_comb begin
    resp_o  = (r_state == StBurst);
    burst_o = 64'd0;
    if ((r_state == StBurst) && !r_op_write) begin
      burst_o = r_mem[r_idx][w_beat_lsb +: 64];
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder. It compares every cycle of each transaction
// against a line-array reference model and checks first-beat timing at several latencies.
module tb_burst_mem_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;

  logic        resp_l0, resp_l1, resp_l5;
  logic [63:0] burst_l0, burst_l1, burst_l5;

  logic [255:0] model [Depth];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(.DEPTH_LINES(Depth), .LATENCY(Lat)) u_dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o)
  );

  burst_mem_responder #(.DEPTH_LINES(Depth), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_l0), .resp_o(resp_l0)
  );

  burst_mem_responder #(.DEPTH_LINES(Depth), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_l1), .resp_o(resp_l1)
  );

  burst_mem_responder #(.DEPTH_LINES(Depth), .LATENCY(5)) u_lat5 (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_l5), .resp_o(resp_l5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[8:5] = 4'(idx);
    return a;
  endfunction

  // One transaction on the main DUT, starting at the IDLE cycle where the request is first high.
  // drop_k: cycle at which the request is dropped early (-1 = none).
  // hold: leave the request high after DONE.
  // abort_k: cycle at which reset is driven, which abandons the transaction (-1 = none).
  task automatic txn(input bit is_wr, input bit both, input logic [31:0] addr,
                     input logic [255:0] data, input int drop_k, input bit hold,
                     input int abort_k, input string name);
    int idx, last, beat;
    bit exp_resp;
    logic [63:0] exp_data;
    idx  = int'(addr[8:5]);
    last = 5 + Lat;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      exp_resp = (k >= 1 + Lat) && (k <= 4 + Lat);
      beat     = k - 1 - Lat;
      exp_data = 64'd0;
      if (exp_resp && !is_wr) exp_data = model[idx][64*beat +: 64];
      check($sformatf("%s resp k=%0d", name, k), {63'd0, resp_o}, {63'd0, exp_resp});
      check($sformatf("%s burst_o k=%0d", name, k), burst_o, exp_data);
      if (k == 0) begin
        reset_n   = 1'b1;
        address_i = addr;
        read_i    = !is_wr || both;
        write_i   = is_wr || both;
      end else begin
        // The address is sampled only at acceptance.
        address_i = $urandom;
      end
      if (k == drop_k) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      if (k == last && !hold) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      if (exp_resp) burst_i = data[64*beat +: 64];
      else          burst_i = {$urandom, $urandom};
      if (k == abort_k) begin
        reset_n = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        return;
      end
      if (exp_resp && is_wr) model[idx][64*beat +: 64] = data[64*beat +: 64];
    end
  endtask

  initial begin
    int first0, first1, first5, firstm;
    int cnt0, cnt1, cnt5, cntm;
    logic [255:0] d;
    int idx, drop;

    reset_n   = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'd0;
    burst_i   = 64'd0;

    // Reset held for two cycles with a read pending: nothing may come out.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("reset resp", {63'd0, resp_o}, 64'd0);
        check("reset burst_o", burst_o, 64'd0);
      end
      reset_n = 1'b0;
      read_i  = 1'b1;
    end

    // Latency sweep: release reset with a read high; first beat at LATENCY+1 cycles.
    first0 = -1; first1 = -1; first5 = -1; firstm = -1;
    cnt0 = 0; cnt1 = 0; cnt5 = 0; cntm = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (resp_l0) begin cnt0++; if (first0 < 0) first0 = k; end
      if (resp_l1) begin cnt1++; if (first1 < 0) first1 = k; end
      if (resp_l5) begin cnt5++; if (first5 < 0) first5 = k; end
      if (resp_o)  begin cntm++; if (firstm < 0) firstm = k; end
      if (k == 0) begin
        reset_n   = 1'b1;
        read_i    = 1'b1;
        address_i = 32'd0;
      end else begin
        read_i = 1'b0;
      end
    end
    check("sweep first lat0", 64'(first0), 64'd1);
    check("sweep first lat1", 64'(first1), 64'd2);
    check("sweep first lat5", 64'(first5), 64'd6);
    check("sweep first lat2", 64'(firstm), 64'(Lat + 1));
    check("sweep beats lat0", 64'(cnt0), 64'd4);
    check("sweep beats lat1", 64'(cnt1), 64'd4);
    check("sweep beats lat5", 64'(cnt5), 64'd4);
    check("sweep beats lat2", 64'(cntm), 64'd4);

    // Write then read back line 0x40.
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1'b1, 1'b0, 32'h40, d, -1, 1'b0, -1, "wr40");
    txn(1'b0, 1'b0, 32'h40, 256'd0, -1, 1'b0, -1, "rd40");

    // Priority: read and write together perform a read and leave the line unchanged.
    txn(1'b1, 1'b0, 32'h20, rand256(), -1, 1'b0, -1, "wr20");
    txn(1'b0, 1'b1, 32'h20, rand256(), -1, 1'b0, -1, "both20");
    txn(1'b0, 1'b0, 32'h20, 256'd0, -1, 1'b0, -1, "rd20");
    // Alias: 0x220 maps to the same line as 0x20.
    txn(1'b1, 1'b0, 32'h220, rand256(), -1, 1'b0, -1, "wr220");
    txn(1'b0, 1'b0, 32'h20, 256'd0, -1, 1'b0, -1, "rd20alias");

    // Early drop during WAIT still delivers four beats.
    txn(1'b0, 1'b0, 32'h40, 256'd0, 1, 1'b0, -1, "rd40drop");
    // Request held through DONE is re-accepted in the very next cycle.
    txn(1'b0, 1'b0, 32'h40, 256'd0, -1, 1'b1, -1, "rd40hold");
    txn(1'b0, 1'b0, 32'h40, 256'd0, -1, 1'b0, -1, "rd40again");

    // Reset during beat 2 of a write: beats 0 and 1 remain, and beats 2 and 3 keep the old line.
    txn(1'b1, 1'b0, 32'hA0, {256{1'b1}}, -1, 1'b0, -1, "wrA0ones");
    d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    txn(1'b1, 1'b0, 32'hA0, d, -1, 1'b0, 3 + Lat, "wrA0abort");
    txn(1'b0, 1'b0, 32'hA0, 256'd0, -1, 1'b0, -1, "rdA0");
    check("abort beat2 model", model[5][191:128], 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized traffic: fill every line, then mix reads and writes with random early drops.
    for (int i = 0; i < int'(Depth); i++) begin
      txn(1'b1, 1'b0, rand_addr(i), rand256(), -1, 1'b0, -1, "fill");
    end
    for (int i = 0; i < 40; i++) begin
      idx  = int'($urandom_range(Depth - 1, 0));
      drop = ($urandom_range(1, 0) != 0) ? int'($urandom_range(5 + Lat, 1)) : -1;
      txn($urandom_range(1, 0) != 0, 1'b0, rand_addr(idx), rand256(), drop, 1'b0, -1,
          $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    check("final idle resp", {63'd0, resp_o}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Memory-side responder for the 4-beat, 64-bit burst protocol the cache-line adaptor issues toward memory. It accepts a line-aligned read or write request, waits a programmable latency, then streams four 64-bit beats with `resp_o` asserted on each beat. Backing storage is an internal array of 256-bit lines. It serves as the synthesizable memory model behind the adaptor in block-level and integration benches.

## Interface
- `DEPTH_LINES`, default 16. Number of 256-bit lines; must be a power of 2, ≥2. IDX_W = log2(DEPTH_LINES).
- `LATENCY`, default 2. Number of idle cycles between request acceptance and the first beat; ≥0.
- `clk`  in  1  Clock; all state changes on the rising edge.
- `reset_n`  in  1  Reset: synchronous, active-low.
- `address_i`  in  32  Request address; bits [4:0] ignored; line index = address_i[5+IDX_W-1:5]; upper bits ignored (alias).
- `read_i`  in  1  Read request; held by the initiator until it sees `resp_o`.
- `write_i`  in  1  Write request; same hold rule as `read_i`.
- `burst_i`  in  64  Write data; beat k valid in the cycle of the k-th `resp_o` pulse.
- `burst_o`  out  64  Read data; beat k valid in the cycle of the k-th `resp_o` pulse; 0 otherwise.
- `resp_o`  out  1  Beat strobe; high for exactly 4 consecutive cycles per transaction.

## Operation
- States: IDLE, WAIT, BURST, DONE. Registers: op (read/write), idx (IDX_W bits), lat_cnt, beat (2 bits).
- IDLE: if `read_i`, accept a read; else if `write_i`, accept a write. Read wins when both are high. On acceptance, latch op and idx, and set beat=0. Go to WAIT if LATENCY>0 (lat_cnt=LATENCY-1), else go to BURST.
- WAIT: decrement lat_cnt; at 0 go to BURST. Request inputs are ignored.
- BURST: `resp_o`=1.
  - Read: `burst_o` = mem[idx][64·beat+63 : 64·beat].
  - Write: at the edge ending the cycle, mem[idx][64·beat+63 : 64·beat] <= `burst_i`.
  - beat increments each cycle. At beat=3, go to DONE.
- DONE: one cycle with `resp_o`=0. Requests are ignored so the initiator can deassert. Next state is IDLE.
- Line layout: beat 0 = bits [63:0], beat 3 = bits [255:192].
- Request drop: deasserting `read_i`/`write_i` in WAIT or BURST has no effect; the transaction always completes all 4 beats. `address_i` is sampled only at acceptance.
- Write commits per beat. A read issued after a completed write returns the new data. Writes to aliased addresses hit the same line.
- Array contents are not cleared by reset. Benches must write a line before checking a read of it.

## Timing
- Let cycle n be the IDLE cycle in which a request is first sampled high.
  - `resp_o` is high in cycles n+1+LATENCY through n+4+LATENCY.
  - DONE occupies cycle n+5+LATENCY.
  - The earliest next acceptance is cycle n+6+LATENCY.
- Throughput: one line per LATENCY+6 cycles when requests are back-to-back.
- A request held high through DONE is re-accepted in the following IDLE cycle as a new transaction. Initiators must drop the request within 1 cycle after the last beat.
- Reset (`reset_n`=0 at an edge): next cycle is IDLE, `resp_o`=0, `burst_o`=0, lat_cnt=0, beat=0.
  - Reset mid-WAIT: the transaction is abandoned, with no beats.
  - Reset mid-BURST write: beats already committed remain in the array. The remaining beats are not written.
  - Reset mid-BURST read: the burst ends immediately.
- `burst_o` is combinational from registered idx/beat and the array. It is 0 whenever `resp_o`=0.

## Test plan
- Reset then idle: hold `reset_n`=0 for 2 cycles with `read_i`=1 → `resp_o`=0 and `burst_o`=0 throughout. After release, the first `resp_o` appears LATENCY+1 cycles later.
- Write then read: write address 0x40 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…. Then read 0x40 → beats are returned in the same order; `resp_o` is high exactly 4 cycles each time; the gap between bursts is ≥2 cycles.
- Priority and alias: with DEPTH_LINES=16, assert `read_i`=`write_i`=1 at 0x20 → read performed, array unchanged. Write 0x220 (aliases index 1), then read 0x20 → returns the 0x220 data.
- Latency sweep: run LATENCY=0, 1, 5 → first `resp_o` arrives at cycle n+1, n+2, n+6 respectively.
- Early drop / held request: drop `read_i` during WAIT → all 4 beats are still delivered. Hold `read_i` through DONE → a second transaction starts exactly at cycle n+6+LATENCY.
- Reset mid-write: write 0xA0 with 0xAA…, 0xBB…, 0xCC…, 0xDD… over an old line of all-ones, and assert reset in the cycle after beat 1. Then read 0xA0 → beats are 0xAA…, 0xBB…, 0xFFFF…, 0xFFFF….
